// File: rtl/serial_port_pkg.sv
// serial_port_pkg: shared widths and defaults for the serial port slice.
// No ports; imported by the interface, FIFO and top.
package serial_port_pkg;

  localparam int SERIAL_BYTE_W = 8;
  localparam int SERIAL_DEPTH_LOG2_DEFAULT = 4;

  typedef logic [SERIAL_BYTE_W-1:0] serial_byte_t;

endpackage

// File: rtl/serial_port_if.sv
// serial_port_if: processor-side and host-side byte streams of serial_port.
// slave = the serial_port device; master = processor plus host driving it.
interface serial_port_if
  import serial_port_pkg::*;
#(
  parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT
);

  serial_byte_t          cpu_wdata_in;
  logic                  cpu_wren_in;
  logic                  cpu_rden_in;
  serial_byte_t          cpu_rdata_out;
  logic                  cpu_valid_out;
  logic                  cpu_ready_out;
  serial_byte_t          host_rx_data_in;
  logic                  host_rx_valid_in;
  logic                  host_rx_ready_out;
  serial_byte_t          host_tx_data_out;
  logic                  host_tx_valid_out;
  logic                  host_tx_ready_in;
  logic                  rx_overrun_out;
  logic                  tx_overrun_out;
  logic [DEPTH_LOG2:0]   rx_count_out;
  logic [DEPTH_LOG2:0]   tx_count_out;

  modport slave (
    input  cpu_wdata_in,
    input  cpu_wren_in,
    input  cpu_rden_in,
    output cpu_rdata_out,
    output cpu_valid_out,
    output cpu_ready_out,
    input  host_rx_data_in,
    input  host_rx_valid_in,
    output host_rx_ready_out,
    output host_tx_data_out,
    output host_tx_valid_out,
    input  host_tx_ready_in,
    output rx_overrun_out,
    output tx_overrun_out,
    output rx_count_out,
    output tx_count_out
  );

  modport master (
    output cpu_wdata_in,
    output cpu_wren_in,
    output cpu_rden_in,
    input  cpu_rdata_out,
    input  cpu_valid_out,
    input  cpu_ready_out,
    output host_rx_data_in,
    output host_rx_valid_in,
    input  host_rx_ready_out,
    input  host_tx_data_out,
    input  host_tx_valid_out,
    output host_tx_ready_in,
    input  rx_overrun_out,
    input  tx_overrun_out,
    input  rx_count_out,
    input  tx_count_out
  );

endinterface

// File: rtl/serial_port_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO, 2**DEPTH_LOG2 entries.
// Ports: clock, reset, push/data_in, pop/data_out, empty, full, count.
module byte_fifo
  import serial_port_pkg::*;
#(
  parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  serial_byte_t        data_in,
  input  logic                pop,
  output serial_byte_t        data_out,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    DEPTH[DEPTH_LOG2:0];

  serial_byte_t          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Masked while empty so the head reads 0 after reset
  // regardless of stale storage contents.
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push_ok & ~pop_ok: count <= count + 1'b1;
        pop_ok & ~push_ok: count <= count - 1'b1;
        default:           count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_port.sv
// serial_port: processor byte I/O device; RX FIFO host->cpu, TX FIFO cpu->host.
// Ports: clock, reset (sync, active-high), sp (serial_port_if.slave).
module serial_port
  import serial_port_pkg::*;
#(
  parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT
) (
  input logic        clock,
  input logic        reset,
  serial_port_if.slave sp
);

  logic rx_empty;
  logic rx_full;
  logic tx_empty;
  logic tx_full;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (sp.host_rx_valid_in),
    .data_in  (sp.host_rx_data_in),
    .pop      (sp.cpu_rden_in),
    .data_out (sp.cpu_rdata_out),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (sp.rx_count_out)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (sp.cpu_wren_in),
    .data_in  (sp.cpu_wdata_in),
    .pop      (sp.host_tx_ready_in),
    .data_out (sp.host_tx_data_out),
    .empty    (tx_empty),
    .full     (tx_full),
    .count    (sp.tx_count_out)
  );

  assign sp.cpu_valid_out     = ~rx_empty;
  assign sp.host_rx_ready_out = ~rx_full;
  assign sp.host_tx_valid_out = ~tx_empty;
  assign sp.cpu_ready_out     = ~tx_full;

  // Set-only error flags; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp.rx_overrun_out <= 1'b0;
      sp.tx_overrun_out <= 1'b0;
    end else begin
      if (sp.cpu_rden_in & rx_empty)
        sp.rx_overrun_out <= 1'b1;
      if (sp.cpu_wren_in & tx_full)
        sp.tx_overrun_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: directed + random stimulus, queue model, decoupled monitor.
// Ports: none.
module tb_serial_port;
  import serial_port_pkg::*;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serial_port_if sp ();

  serial_port dut (
    .clock (clock),
    .reset (reset),
    .sp    (sp.slave)
  );

  int errors = 0;
  int checks = 0;

  serial_byte_t sb_rx[$];
  serial_byte_t sb_tx[$];
  int m_rx = 0;
  int m_tx = 0;
  bit m_rxo = 0;
  bit m_txo = 0;
  bit armed = 0;
  bit after_rst = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("cpu_valid", 32'(sp.cpu_valid_out), 32'(m_rx > 0));
    chk("host_rx_ready", 32'(sp.host_rx_ready_out),
        32'(m_rx < DEPTH));
    chk("host_tx_valid", 32'(sp.host_tx_valid_out),
        32'(m_tx > 0));
    chk("cpu_ready", 32'(sp.cpu_ready_out), 32'(m_tx < DEPTH));
    chk("rx_count", 32'(sp.rx_count_out), m_rx);
    chk("tx_count", 32'(sp.tx_count_out), m_tx);
    chk("rx_overrun", 32'(sp.rx_overrun_out), 32'(m_rxo));
    chk("tx_overrun", 32'(sp.tx_overrun_out), 32'(m_txo));
    if (after_rst) begin
      chk("rst_cpu_rdata", 32'(sp.cpu_rdata_out), 0);
      chk("rst_host_tx_data", 32'(sp.host_tx_data_out), 0);
    end
  endtask

  // One clock: check outputs of the previous edge, drive inputs,
  // then advance the model to what the next edge must produce.
  task automatic cycle(input bit rst,
                       input bit hv, input serial_byte_t hd,
                       input bit rden,
                       input bit wren, input serial_byte_t wd,
                       input bit hrdy);
    bit rx_push, rx_pop, tx_push, tx_pop;
    @(negedge clock);
    #1;
    if (armed) check_state();
    reset               = rst;
    sp.host_rx_valid_in = hv;
    sp.host_rx_data_in  = hd;
    sp.cpu_rden_in      = rden;
    sp.cpu_wren_in      = wren;
    sp.cpu_wdata_in     = wd;
    sp.host_tx_ready_in = hrdy;
    if (rst) begin
      m_rx = 0; m_tx = 0; m_rxo = 0; m_txo = 0;
      sb_rx.delete();
      sb_tx.delete();
      after_rst = 1;
      armed = 1;
    end else begin
      after_rst = 0;
      rx_push = hv && (m_rx < DEPTH);
      rx_pop  = rden && (m_rx > 0);
      if (rden && m_rx == 0) m_rxo = 1;
      if (rx_push) sb_rx.push_back(hd);
      m_rx = m_rx + int'(rx_push) - int'(rx_pop);
      tx_push = wren && (m_tx < DEPTH);
      tx_pop  = hrdy && (m_tx > 0);
      if (wren && m_tx == DEPTH) m_txo = 1;
      if (tx_push) sb_tx.push_back(wd);
      m_tx = m_tx + int'(tx_push) - int'(tx_pop);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  // Monitor: compares every byte the DUT hands over on a handshake.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (armed && !reset) begin
        if (sp.cpu_valid_out && sp.cpu_rden_in) begin
          if (sb_rx.size() == 0)
            chk("rx_unexpected", 32'(sp.cpu_rdata_out), 32'hFFFF);
          else
            chk("rx_data", 32'(sp.cpu_rdata_out),
                32'(sb_rx.pop_front()));
        end
        if (sp.host_tx_valid_out && sp.host_tx_ready_in) begin
          if (sb_tx.size() == 0)
            chk("tx_unexpected", 32'(sp.host_tx_data_out), 32'hFFFF);
          else
            chk("tx_data", 32'(sp.host_tx_data_out),
                32'(sb_tx.pop_front()));
        end
      end
    end
  end

  initial begin
    sp.host_rx_valid_in = 0;
    sp.host_rx_data_in  = 0;
    sp.cpu_rden_in      = 0;
    sp.cpu_wren_in      = 0;
    sp.cpu_wdata_in     = 0;
    sp.host_tx_ready_in = 0;

    // Reset state
    cycle(1, 0, 8'h00, 0, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0, 0, 8'h00, 0);
    idle(2);

    // Two host bytes, CPU pops both, then empty
    cycle(0, 1, 8'hA5, 0, 0, 8'h00, 0);
    cycle(0, 1, 8'h3C, 0, 0, 8'h00, 0);
    idle(1);
    cycle(0, 0, 8'h00, 1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 1, 0, 8'h00, 0);
    idle(2);

    // Fill TX, overflow, drain in order
    for (int i = 0; i < 16; i++)
      cycle(0, 0, 8'h00, 0, 1, 8'(i), 0);
    cycle(0, 0, 8'h00, 0, 1, 8'hFF, 0);
    idle(1);
    for (int i = 0; i < 18; i++)
      cycle(0, 0, 8'h00, 0, 0, 8'h00, 1);
    idle(1);

    // Pointer wrap with steady occupancy of 8
    for (int i = 0; i < 8; i++)
      cycle(0, 1, 8'(8'h40 + i), 0, 0, 8'h00, 0);
    for (int i = 8; i < 40; i++)
      cycle(0, 1, 8'(8'h40 + i), 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 8'h00, 1, 0, 8'h00, 0);
    idle(2);

    // RX underrun sets a sticky flag
    cycle(0, 0, 8'h00, 1, 0, 8'h00, 0);
    idle(3);

    // Reset mid-drain with five bytes queued
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 8'h00, 0, 1, 8'(8'h90 + i), 0);
    cycle(0, 0, 8'h00, 0, 0, 8'h00, 1);
    cycle(1, 1, 8'h77, 1, 1, 8'h66, 1);
    cycle(0, 0, 8'h00, 0, 0, 8'h00, 1);
    idle(2);

    // Random traffic with shifting biases and rare resets
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pr, pw, ph_rdy;
      pv = $urandom_range(20, 90);
      pr = $urandom_range(20, 90);
      pw = $urandom_range(20, 90);
      ph_rdy = $urandom_range(20, 90);
      for (int i = 0; i < 500; i++) begin
        bit rst;
        rst = ($urandom_range(0, 599) == 0);
        cycle(rst,
              $urandom_range(0, 99) < pv, 8'($urandom),
              $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < pw, 8'($urandom),
              $urandom_range(0, 99) < ph_rdy);
      end
    end

    // Bounded drain of both directions
    for (int i = 0; i < 40; i++) begin
      if (m_rx == 0 && m_tx == 0) break;
      cycle(0, 0, 8'h00, m_rx > 0, 0, 8'h00, 1);
    end
    idle(3);
    chk("drain_rx_model", 32'(m_rx), 0);
    chk("drain_tx_model", 32'(m_tx), 0);
    chk("sb_rx_left", 32'(sb_rx.size()), 0);
    chk("sb_tx_left", 32'(sb_tx.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
